prog_mem: RTL and testbench

Program memory and loader for the 4-bit CPU. Holds sixteen 8-bit instructions and drives the CPU's `instr` input combinationally from the CPU's `address` (PC) output. A byte-stream loader with a valid/ready handshake rewrites the whole program at run time. While the loader runs, `cpu_n_reset` holds the CPU in reset, and it releases the CPU once the new program is complete.

---
 rtl/prog_mem.sv | 150 +++++++++++++++
 tb/tb_prog_mem.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem.sv
// Program memory (16 x 8) for the 4-bit CPU with a valid/ready byte-stream loader.
// Optional checksum byte and error state are enabled by defining PROG_MEM_CKSUM_EN.
module prog_mem (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [3:0] address,
  output logic [7:0] instr,
  input  logic       load_start,
  input  logic [7:0] load_data,
  input  logic       load_valid,
  output logic       load_ready,
  output logic [3:0] load_addr,
  output logic       load_busy,
  output logic       load_error,
  output logic       cpu_n_reset
);

`ifdef PROG_MEM_CKSUM_EN
  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StLoad  = 2'd1,
    StCksum = 2'd2,
    StError = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StLoad = 2'd1
  } state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] mem_q [16];
  logic [3:0] addr_q, addr_d;
  logic       cpu_n_reset_q;
  logic       accept;
  logic       wr_en;

`ifdef PROG_MEM_CKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] cksum_total;
  logic       err_q, err_d;

  assign cksum_total = sum_q + load_data;
`endif

  assign instr     = mem_q[address];
  assign load_addr = addr_q;
  assign load_busy = (state_q != StRun);
  assign accept    = load_valid && load_ready;

`ifdef PROG_MEM_CKSUM_EN
  assign load_ready = (state_q == StLoad) || (state_q == StCksum);
  assign load_error = err_q;
`else
  assign load_ready = (state_q == StLoad);
  assign load_error = 1'b0;
`endif

  assign cpu_n_reset = cpu_n_reset_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_en   = 1'b0;
`ifdef PROG_MEM_CKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StRun: begin
        // load_valid is ignored here, even together with load_start
        if (load_start) begin
          state_d = StLoad;
          addr_d  = 4'd0;
`ifdef PROG_MEM_CKSUM_EN
          sum_d   = 8'h00;
`endif
        end
      end
      StLoad: begin
        if (accept) begin
          wr_en  = 1'b1;
          addr_d = addr_q + 4'd1;
`ifdef PROG_MEM_CKSUM_EN
          sum_d  = cksum_total;
          if (addr_q == 4'd15) state_d = StCksum;
`else
          if (addr_q == 4'd15) state_d = StRun;
`endif
        end
      end
`ifdef PROG_MEM_CKSUM_EN
      StCksum: begin
        if (accept) begin
          if (cksum_total == 8'h00) begin
            state_d = StRun;
          end else begin
            state_d = StError;
            err_d   = 1'b1;
          end
        end
      end
      StError: begin
        if (load_start) begin
          state_d = StLoad;
          addr_d  = 4'd0;
          sum_d   = 8'h00;
          err_d   = 1'b0;
        end
      end
`endif
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q       <= StRun;
      addr_q        <= 4'd0;
      cpu_n_reset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      // Registered so the CPU sees a clean, glitch-free reset.
      cpu_n_reset_q <= (state_d == StRun);
    end
  end

`ifdef PROG_MEM_CKSUM_EN
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sum_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
    end else if (wr_en) begin
      mem_q[addr_q] <= load_data;
    end
  end

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: reset, full/gapped loads, ignored inputs, reset mid-load,
// and (with PROG_MEM_CKSUM_EN) checksum pass/fail handling.
module tb_prog_mem;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [3:0] address;
  logic [7:0] instr;
  logic       load_start;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_addr;
  logic       load_busy;
  logic       load_error;
  logic       cpu_n_reset;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] pgm     [16];
  logic [7:0] exp_mem [16];

  prog_mem dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .address     (address),
    .instr       (instr),
    .load_start  (load_start),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_busy   (load_busy),
    .load_error  (load_error),
    .cpu_n_reset (cpu_n_reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      check(tag, instr, exp_mem[a]);
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("start_busy", load_busy, 1);
    check("start_ready", load_ready, 1);
    check("start_cpu_held", cpu_n_reset, 0);
    check("start_addr", load_addr, 0);
  endtask

  // Streams pgm[0..15]; with gaps, load_valid toggles randomly and idle data is junk.
  task automatic stream(input bit gaps);
    int n = 0;
    int cyc = 0;
    while (n < 16 && cyc < 300) begin
      load_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      load_data  = load_valid ? pgm[n] : 8'hFF;
      address    = 4'(n);
      if (!gaps && n == 5) load_start = 1'b1;
      check("load_addr", load_addr, n);
      tick();
      load_start = 1'b0;
      if (load_valid) begin
        exp_mem[n] = pgm[n];
        check("wr_visible", instr, pgm[n]);
        n++;
      end
      if (n < 16) check("cpu_held", cpu_n_reset, 0);
      cyc++;
    end
    load_valid = 1'b0;
    if (n < 16) check("stream_timeout", n, 16);
  endtask

  task automatic finish_load(input logic [7:0] adj, input bit ok);
`ifdef PROG_MEM_CKSUM_EN
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 16; i++) s = s + pgm[i];
    check("cksum_cpu_held", cpu_n_reset, 0);
    check("cksum_ready", load_ready, 1);
    check("cksum_addr", load_addr, 0);
    load_data  = 8'h00 - s + adj;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    if (!ok) begin
      check("err_flag", load_error, 1);
      check("err_busy", load_busy, 1);
      check("err_cpu_held", cpu_n_reset, 0);
      check("err_ready", load_ready, 0);
      return;
    end
`endif
    check("done_cpu_run", cpu_n_reset, 1);
    check("done_busy", load_busy, 0);
    check("done_ready", load_ready, 0);
    check("done_addr", load_addr, 0);
    check("done_error", load_error, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_reset    = 1'b0;
    address    = 4'd0;
    load_start = 1'b0;
    load_data  = 8'h00;
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

    // Reset held three cycles
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_cpu_held", cpu_n_reset, 0);
      check("rst_ready", load_ready, 0);
      check("rst_busy", load_busy, 0);
      check("rst_addr", load_addr, 0);
      check("rst_error", load_error, 0);
    end
    check_mem("rst_mem");
    n_reset = 1'b1;
    #1;
    check("rel_cpu_still_held", cpu_n_reset, 0);
    tick();
    check("rel_cpu_run", cpu_n_reset, 1);

    // Full back-to-back load, with a stray load_start mid-load
    pgm[0] = 8'hB3;
    for (int i = 1; i < 16; i++) pgm[i] = 8'(i);
    start_load();
    stream(1'b0);
    finish_load(8'h00, 1'b1);
    check_mem("full_mem");

    // load_valid in RUN is ignored
    load_valid = 1'b1;
    load_data  = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      check("run_ready", load_ready, 0);
      tick();
    end
    load_valid = 1'b0;
    check("run_addr", load_addr, 0);
    check_mem("run_ignore_mem");

    // load_start and load_valid together in RUN: no byte taken
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    check("same_busy", load_busy, 1);
    check("same_addr", load_addr, 0);
    address = 4'd0;
    #1;
    check("same_mem0", instr, 8'hB3);

    // Gapped load continues from that LOAD
    for (int i = 0; i < 16; i++) pgm[i] = 8'h40 + 8'(i);
    stream(1'b1);
    finish_load(8'h00, 1'b1);
    check_mem("gap_mem");

    // Reset after seven bytes
    start_load();
    for (int i = 0; i < 7; i++) begin
      load_data  = 8'h90 + 8'(i);
      load_valid = 1'b1;
      tick();
    end
    load_valid = 1'b0;
    check("mid_addr7", load_addr, 7);
    n_reset = 1'b0;
    tick();
    check("mid_cpu_held", cpu_n_reset, 0);
    check("mid_busy", load_busy, 0);
    check("mid_addr", load_addr, 0);
    check("mid_ready", load_ready, 0);
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    check_mem("mid_mem");
    n_reset = 1'b1;
    tick();
    check("mid_rel_cpu", cpu_n_reset, 1);

`ifdef PROG_MEM_CKSUM_EN
    // 16 x 01 sums to 0x10: C=F0 passes, C=F1 fails
    for (int i = 0; i < 16; i++) pgm[i] = 8'h01;
    start_load();
    stream(1'b0);
    check("ck_pass_value", 8'h00 - 8'h10, 8'hF0);
    finish_load(8'h00, 1'b1);
    start_load();
    stream(1'b0);
    finish_load(8'h01, 1'b0);
    tick();
    tick();
    check("err_sticky", load_error, 1);
    check("err_cpu_sticky", cpu_n_reset, 0);
    start_load();
    check("err_cleared", load_error, 0);
    stream(1'b0);
    finish_load(8'h00, 1'b1);
    check_mem("ck_mem");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
